mem_arbiter: RTL

- N-master to 1-slave arbiter on the PicoRV32 native memory interface (valid/instr/ready/addr/wdata/wstrb/rdata).
- Sits between request sources (CPU, debug/loader port, DMA) and a single bram_controller.
- Replaces the hand-muxed monitor/CPU select with a registered, handshake-correct arbiter.
- Adds a bus-timeout guard so that a silent slave cannot hang the system.

---
 rtl/mem_if_pkg.sv | 22 ++
 rtl/mem_arb_select.sv | 50 +++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared types for the PicoRV32-style native memory bus and its arbiter.
package mem_if_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // One request as presented on the bus; wstrb == 0 means read.
  typedef struct packed {
    logic                instr;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
  } mem_req_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner select for mem_arbiter.
// MEM_ARB_ROUND_ROBIN_EN: search starts at (i_last + 1) mod N and wraps;
// otherwise the lowest requesting index wins.
module mem_arb_select #(
  parameter int unsigned  N  = 2,
  localparam int unsigned IW = mem_if_pkg::idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_cand;
  logic          w_found;

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Pointer only matters for round-robin.
  logic w_unused_last;
  assign w_unused_last = ^i_last;
`endif

  // Pick the first requester in search order.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = IW'((32'(i_last) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
`else
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IW'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-master to 1-slave arbiter for the PicoRV32 native memory interface with a
// bus-timeout guard. Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_arbiter #(
  parameter int unsigned       N_MASTERS      = 2,
  parameter int unsigned       ADDR_W         = mem_if_pkg::ADDR_W,
  parameter int unsigned       DATA_W         = mem_if_pkg::DATA_W,
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = DATA_W'(32'hDEAD_BEEF),
  localparam int unsigned      STRB_W         = DATA_W / 8,
  localparam int unsigned      GNT_W          = mem_if_pkg::idx_width(N_MASTERS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [N_MASTERS-1:0]             m_valid,
  input  logic [N_MASTERS-1:0]             m_instr,
  input  logic [N_MASTERS-1:0][ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS-1:0][DATA_W-1:0] m_wdata,
  input  logic [N_MASTERS-1:0][STRB_W-1:0] m_wstrb,
  output logic [N_MASTERS-1:0]             m_ready,
  output logic [DATA_W-1:0]                m_rdata,
  output logic                             s_valid,
  output logic                             s_instr,
  output logic [ADDR_W-1:0]                s_addr,
  output logic [DATA_W-1:0]                s_wdata,
  output logic [STRB_W-1:0]                s_wstrb,
  input  logic                             s_ready,
  input  logic [DATA_W-1:0]                s_rdata,
  output logic                             timeout_err,
  output logic [GNT_W-1:0]                 grant_id
);

  import mem_if_pkg::*;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t           r_state, w_state_d;
  logic                 r_s_valid, r_s_instr;
  logic [ADDR_W-1:0]    r_s_addr;
  logic [DATA_W-1:0]    r_s_wdata;
  logic [STRB_W-1:0]    r_s_wstrb;
  logic [N_MASTERS-1:0] r_m_ready;
  logic [DATA_W-1:0]    r_m_rdata;
  logic                 r_timeout_err;
  logic [GNT_W-1:0]     r_grant, r_last;
  logic [CNT_W-1:0]     r_cnt;

  logic [N_MASTERS-1:0] w_gnt;
  logic [GNT_W-1:0]     w_gnt_idx;
  logic                 w_accept, w_finish, w_timeout, w_cnt_hit;

  mem_arb_select #(
    .N (N_MASTERS)
  ) u_select (
    .i_req  (m_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_gnt_idx)
  );

  assign w_cnt_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_d;
  end

  // Next state plus transition strobes; s_ready beats a same-cycle timeout.
  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_finish  = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_accept  = 1'b1;
          w_state_d = BUSY;
        end
      end
      BUSY: begin
        if (s_ready || w_cnt_hit) begin
          w_finish  = 1'b1;
          w_timeout = !s_ready;
          w_state_d = DONE;
        end
      end
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Datapath: latch the winner, hold it through BUSY, register the response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s_valid     <= 1'b0;
      r_s_instr     <= 1'b0;
      r_s_addr      <= '0;
      r_s_wdata     <= '0;
      r_s_wstrb     <= '0;
      r_m_ready     <= '0;
      r_m_rdata     <= '0;
      r_timeout_err <= 1'b0;
      r_grant       <= '0;
      r_last        <= GNT_W'(N_MASTERS - 1);
      r_cnt         <= '0;
    end else begin
      r_m_ready     <= '0;
      r_timeout_err <= 1'b0;
      if (w_accept) begin
        r_s_valid <= 1'b1;
        r_s_instr <= m_instr[w_gnt_idx];
        r_s_addr  <= m_addr[w_gnt_idx];
        r_s_wdata <= m_wdata[w_gnt_idx];
        r_s_wstrb <= m_wstrb[w_gnt_idx];
        r_grant   <= w_gnt_idx;
      end
      if (r_state == BUSY) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_finish) begin
        r_s_valid     <= 1'b0;
        r_m_rdata     <= w_timeout ? TIMEOUT_RDATA : s_rdata;
        r_timeout_err <= w_timeout;
        r_m_ready     <= N_MASTERS'(1) << r_grant;
        r_last        <= r_grant;
      end
    end
  end

  assign s_valid     = r_s_valid;
  assign s_instr     = r_s_instr;
  assign s_addr      = r_s_addr;
  assign s_wdata     = r_s_wdata;
  assign s_wstrb     = r_s_wstrb;
  assign m_ready     = r_m_ready;
  assign m_rdata     = r_m_rdata;
  assign timeout_err = r_timeout_err;
  assign grant_id    = r_grant;

endmodule
